// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative radix-2 multiply / restoring divide beside the ALU.
// Ports: clk, rst_n, in_valid/in_ready, op, a, b, flush -> busy, done, hi, lo,
// div_by_zero. Define MULDIV_DIV_EN to build the divide datapath.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opd;
  logic               neg_q;

  logic               is_div;
  logic               is_sgn;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     add;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               fix_dbz;

  assign is_div = op_q[1];
  assign is_sgn = ~op_q[0];
  assign busy   = ~in_ready;

  // In PREP acc_lo still holds a and opd holds b.
  assign abs_a = (is_sgn && acc_lo[WIDTH-1]) ? -acc_lo : acc_lo;
  assign abs_b = (is_sgn && opd[WIDTH-1]) ? -opd : opd;

  // Multiplier bits shift out of acc_lo as product bits shift in.
  assign add  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
  assign prod = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

`ifdef MULDIV_DIV_EN
  logic           neg_r;
  logic           b_zero;
  logic [WIDTH:0] sh;
  logic           ge;

  assign sh = {acc_hi, acc_lo[WIDTH-1]};
  assign ge = sh >= {1'b0, opd};
`endif

  always_comb begin
    step_hi = add[WIDTH:1];
    step_lo = {add[0], acc_lo[WIDTH-1:1]};
    fix_hi  = prod[2*WIDTH-1:WIDTH];
    fix_lo  = prod[WIDTH-1:0];
    fix_dbz = 1'b0;
    if (is_div) begin
`ifdef MULDIV_DIV_EN
      // Remainder fits WIDTH bits once ge holds.
      step_hi = ge ? sh[WIDTH-1:0] - opd : sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ge};
      // With b == 0 the loop shifts |a| into acc_hi, so the
      // sign-corrected remainder is a itself.
      fix_hi  = neg_r ? -acc_hi : acc_hi;
      fix_lo  = b_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
      fix_dbz = b_zero;
`else
      step_hi = acc_hi;
      step_lo = acc_lo;
      fix_hi  = '1;
      fix_lo  = '1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opd         <= '0;
      neg_q       <= 1'b0;
      in_ready    <= 1'b1;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (flush && state != IDLE) begin
        state    <= IDLE;
        in_ready <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (in_valid) begin
              state    <= PREP;
              in_ready <= 1'b0;
              op_q     <= op;
              acc_hi   <= '0;
              acc_lo   <= a;
              opd      <= b;
            end
          end
          PREP: begin
            state <= RUN;
            cnt   <= CW'(WIDTH);
            neg_q <= is_sgn & (acc_lo[WIDTH-1] ^ opd[WIDTH-1]);
            if (is_div) begin
              acc_lo <= abs_a;
              opd    <= abs_b;
            end else begin
              acc_lo <= abs_b;
              opd    <= abs_a;
            end
`ifdef MULDIV_DIV_EN
            neg_r  <= is_sgn & acc_lo[WIDTH-1];
            b_zero <= (opd == '0);
`endif
          end
          RUN: begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= FIX;
          end
          FIX: begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            done        <= 1'b1;
            hi          <= fix_hi;
            lo          <= fix_lo;
            div_by_zero <= fix_dbz;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv, WIDTH = 32.
// Divide expectations follow whether MULDIV_DIV_EN is defined.
module tb_alu_muldiv;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int total  = 0;
  int passed = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp_res,
                        input logic exp_dbz, input string name);
    int n;
    issue(o, x, y);
    wait_done(n);
    total++;
    if (n !== 34) $display("FAIL %s latency: got %0d want 34", name, n);
    else passed++;
    total++;
    if ({hi, lo} !== exp_res)
      $display("FAIL %s result: got %h want %h", name, {hi, lo}, exp_res);
    else passed++;
    total++;
    if (div_by_zero !== exp_dbz)
      $display("FAIL %s dbz: got %b want %b", name, div_by_zero, exp_dbz);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    #12;
    total++;
    if ({in_ready, busy, done, div_by_zero, hi, lo} !== {4'b1000, 64'h0})
      $display("FAIL reset_hold: got %b%b%b%b %h want 1000 0", in_ready,
               busy, done, div_by_zero, {hi, lo});
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({in_ready, busy, done, div_by_zero, hi, lo} !== {4'b1000, 64'h0})
      $display("FAIL reset_release: got %b%b%b%b %h want 1000 0", in_ready,
               busy, done, div_by_zero, {hi, lo});
    else passed++;
  endtask

  task automatic test_mult;
    run_op(2'b00, 32'hFFFF_FFFE, 32'h3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0,
           "mult_neg2x3");
    total++;
    if ({in_ready, busy} !== 2'b10)
      $display("FAIL mult_ready: got %b%b want 10", in_ready, busy);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done);
    else passed++;
    run_op(2'b01, 32'hFFFF_FFFE, 32'h3, 64'h0000_0002_FFFF_FFFA, 1'b0,
           "multu_big");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, 1'b0, "mult_m1m1");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000,
           1'b0, "mult_minmin");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
           1'b0, "multu_max");
  endtask

  task automatic test_div;
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2,
           DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFD : '1, 1'b0, "div_m7_2");
    run_op(2'b11, 32'd100, 32'd7,
           DIV_EN ? {32'd2, 32'd14} : '1, 1'b0, "divu_100_7");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE,
           DIV_EN ? {32'd1, 32'hFFFF_FFFD} : '1, 1'b0, "div_7_m2");
  endtask

  task automatic test_corner;
    run_op(2'b11, 32'h1234_5678, 32'h0,
           DIV_EN ? {32'h1234_5678, 32'hFFFF_FFFF} : '1, DIV_EN,
           "divu_by_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           DIV_EN ? {32'h0, 32'h8000_0000} : '1, 1'b0, "div_overflow");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0,
           DIV_EN ? {32'hFFFF_FFF9, 32'hFFFF_FFFF} : '1, DIV_EN,
           "div_neg_by_zero");
  endtask

  task automatic test_flush;
    int n;
    int seen;
    run_op(2'b01, 32'd7, 32'd6, 64'd42, 1'b0, "flush_prior");
    issue(2'b01, 32'd5, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    total++;
    if ({in_ready, busy, done} !== 3'b100)
      $display("FAIL flush_idle: got %b%b%b want 100", in_ready, busy, done);
    else passed++;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL flush_no_done: got %0d want 0", seen);
    else passed++;
    total++;
    if ({hi, lo} !== 64'd42)
      $display("FAIL flush_hold: got %h want %h", {hi, lo}, 64'd42);
    else passed++;
    run_op(2'b01, 32'd3, 32'd4, 64'd12, 1'b0, "after_flush");
    issue(2'b01, 32'd9, 32'd9);
    repeat (33) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    total++;
    if ({done, in_ready, hi, lo} !== {2'b01, 64'd12})
      $display("FAIL flush_fix: got %b%b %h want 01 %h", done, in_ready,
               {hi, lo}, 64'd12);
    else passed++;
    @(negedge clk);
    op = 2'b01;
    a = 32'd2;
    b = 32'd3;
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL flush_accept: got %b want 1", busy);
    else passed++;
    wait_done(n);
    total++;
    if (n !== 34 || {hi, lo} !== 64'd6)
      $display("FAIL flush_accept_res: got %0d %h want 34 %h", n, {hi, lo},
               64'd6);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int n;
    int m;
    @(negedge clk);
    op = 2'b01;
    a = 32'd5;
    b = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    op = 2'b01;
    a = 32'd3;
    b = 32'd7;
    wait_done(n);
    total++;
    if (n !== 34 || {hi, lo} !== 64'd25)
      $display("FAIL b2b_first: got %0d %h want 34 %h", n, {hi, lo}, 64'd25);
    else passed++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: got %b want 1", busy);
    else passed++;
    wait_done(m);
    total++;
    if (m + 1 !== 35 || {hi, lo} !== 64'd21)
      $display("FAIL b2b_second: got %0d %h want 35 %h", m + 1, {hi, lo},
               64'd21);
    else passed++;
  endtask

  task automatic test_async_reset;
    int seen;
    issue(2'b01, 32'd5, 32'd6);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, busy, done, div_by_zero, hi, lo} !== {4'b1000, 64'h0})
      $display("FAIL async_reset: got %b%b%b%b %h want 1000 0", in_ready,
               busy, done, div_by_zero, {hi, lo});
    else passed++;
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    total++;
    if (seen !== 0 || in_ready !== 1'b1)
      $display("FAIL reset_no_done: got %0d %b want 0 1", seen, in_ready);
    else passed++;
    run_op(2'b01, 32'd5, 32'd6, 64'd30, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_corner();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit, parametrised in operand width, that implements the MUL/DIV operations the single-cycle ALU leaves as placeholders. Sits beside the ALU in the execute stage. Accepts one operation per request through a valid/ready handshake, runs a radix-2 shift/add (multiply) or restoring shift/subtract (divide) loop over `WIDTH` cycles, and holds the double-width result in HI/LO registers until the next completion.

## Interface
- `WIDTH`, default 32: operand width. Must be ≥ 4. HI and LO are each `WIDTH` bits.
- `clk` input, 1 bit: clock. All state changes on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `in_valid` input, 1 bit: request present.
- `in_ready` output, 1 bit: unit idle; a request is accepted on an edge where `in_valid && in_ready`.
- `op` input, 2 bits: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `a` input, `WIDTH` bits: multiplicand or dividend.
- `b` input, `WIDTH` bits: multiplier or divisor.
- `flush` input, 1 bit: abort the in-flight operation.
- `busy` output, 1 bit: operation in flight. Equals `~in_ready`.
- `done` output, 1 bit: one-cycle pulse when HI/LO have just been updated.
- `hi` output, `WIDTH` bits: product upper half, or remainder.
- `lo` output, `WIDTH` bits: product lower half, or quotient.
- `div_by_zero` output, 1 bit: registered flag, valid with `done`; set when the completed op was DIV/DIVU with `b == 0`.

## Operation
- **State machine.** States are IDLE, PREP, RUN, FIX.
  - IDLE → PREP on accept. The unit latches `op`, `a` and `b`.
  - PREP → RUN. Signed ops convert operands to magnitudes and record the result signs: product sign = `a[W-1]^b[W-1]`, quotient sign = same, remainder sign = `a[W-1]`.
  - RUN lasts exactly `WIDTH` cycles. A down-counter of width `$clog2(WIDTH+1)` runs from `WIDTH` to 1, then RUN → FIX.
  - FIX applies sign correction, writes HI/LO, pulses `done`, and → IDLE.
- **Multiply.** The 2·`WIDTH`-bit product is exact for all operand pairs. MULT(-1, -1) gives HI = 0, LO = 1.
- **Divide.** Quotient truncates toward zero. The remainder takes the sign of the dividend.
- **Divide by zero.** HI = `a` unmodified, LO = all ones, `div_by_zero` = 1. Latency is unchanged.
- **Signed overflow.** DIV with `a` = most-negative and `b` = -1 gives LO = `a`, HI = 0, `div_by_zero` = 0.
- **Flush.** In PREP, RUN or FIX, `flush` returns the unit to IDLE on the next edge. There is no `done`; HI, LO and `div_by_zero` keep their previous values. `flush` in IDLE has no effect.
- **Flush and accept on the same edge.** In IDLE, `flush` together with `in_valid` still accepts the request, because flush applies only to in-flight work.
- **Requests while busy.** `in_valid` while busy is ignored (`in_ready` = 0). The requester holds it until accepted.
- **Operand stability.** `a`, `b` and `op` are sampled only on the accept edge; later changes have no effect.

## Timing
- **Reset values:** `in_ready` = 1, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0, `div_by_zero` = 0. State is IDLE.
- **Latency.** If the accept edge is edge 0, `done` is high during the cycle after edge `WIDTH`+2, and HI/LO show new values from that same edge. That is 34 cycles for `WIDTH` = 32.
- **Ready.** `in_ready` rises together with `done`, so back-to-back ops are possible. A request presented during the `done` cycle is accepted on that edge, giving an issue interval of `WIDTH`+3 edges.
- **Outputs.** All outputs are registered; there are no combinational input-to-output paths.
- **Reset mid-operation.** Asserting `rst_n` low forces the reset values immediately. The outcome is identical at any point in the operation.

## Configuration
- **`MULDIV_DIV_EN` defined:** full behaviour as above.
- **`MULDIV_DIV_EN` undefined:** the divide datapath is compiled out. DIV and DIVU are still accepted and still take `WIDTH`+2 cycles to `done`. They return HI = LO = all ones and `div_by_zero` = 0. Multiply is unaffected.

## Test plan
- **Reset.** Hold `rst_n` = 0, then release. Expect `in_ready` = 1, HI = LO = 0, `done` = 0.
- **MULT.** `WIDTH` = 32, MULT a = 0xFFFFFFFE (-2), b = 0x00000003. After 34 cycles `done` pulses with HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. MULTU with the same operands gives HI = 0x00000002, LO = 0xFFFFFFFA.
- **Signed divide.** DIV a = -7 (0xFFFFFFF9), b = 2. Expect LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIVU a = 100, b = 7 gives LO = 14, HI = 2.
- **Corner cases.** DIVU a = 0x12345678, b = 0 gives LO = 0xFFFFFFFF, HI = 0x12345678, `div_by_zero` = 1. DIV a = 0x80000000, b = 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **Flush.** Start MULTU 5×5, assert `flush` at cycle 10. Expect no `done`, HI/LO still holding the prior result, and `in_ready` = 1 on the next edge. Then a new MULTU 3×4 yields LO = 12 after 34 cycles.
- **Back-to-back and async reset.** Present a second request during the `done` cycle; expect it accepted immediately and completing 35 cycles after the first `done`. Drop `rst_n` mid-RUN; expect reset values at once and no `done`.
